// File: rtl/obj_dma_ctrl.sv
// Copies WORDS 16-bit words from object RAM to the object buffer, starting on a VBLK rising edge once a copy has been requested.
// Latency: starts the cycle after the qualifying VBLK edge; 2 cycles per word (READ, WRITE), DONE one cycle after the last write.
// Backpressure: the copy never stalls; the CPU is held off through CPU_WAIT while a copy owns object RAM.
module obj_dma_ctrl #(
    parameter int WORDS  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              DCLK,
    input  logic              RESET,
    input  logic              VBLK,
    input  logic              DMA_REQ_WR,
    input  logic              CPU_RAM_REQ,
    output logic              CPU_WAIT,
    output logic [ADDR_W-1:0] SRC_ADDR,
    output logic              SRC_RD,
    input  logic [15:0]       SRC_DATA,
    output logic [ADDR_W-1:0] DST_ADDR,
    output logic [15:0]       DST_DATA,
    output logic              DST_WE,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned     LAST_I   = WORDS - 1;
    localparam logic [ADDR_W:0] LAST_CNT = LAST_I[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] cnt;
    logic            pending;
    logic            vblk_q;
    logic            vblk_armed;
    logic            done_q;
    logic            vblk_rise;
    logic            start;
    logic            last_wr;

    // An edge only counts once VBLK has been observed low since reset,
    // so a blank already in progress at reset release is not mistaken for a new one.
    assign vblk_rise = VBLK & ~vblk_q & vblk_armed;
    assign start     = (state == ST_IDLE) && vblk_rise && (pending || DMA_REQ_WR);
    assign last_wr   = (state == ST_WRITE) && (cnt == LAST_CNT);

    assign DST_DATA  = SRC_DATA;
    assign CPU_WAIT  = CPU_RAM_REQ & BUSY;
    assign DONE      = done_q;

    // State register.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state RAM strobes; addresses are held at zero outside their state.
    always_comb begin
        state_nxt = state;
        SRC_RD    = 1'b0;
        SRC_ADDR  = '0;
        DST_WE    = 1'b0;
        DST_ADDR  = '0;
        BUSY      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                BUSY      = 1'b1;
                SRC_RD    = 1'b1;
                SRC_ADDR  = cnt[ADDR_W-1:0];
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                BUSY      = 1'b1;
                DST_WE    = 1'b1;
                DST_ADDR  = cnt[ADDR_W-1:0];
                state_nxt = last_wr ? ST_IDLE : ST_READ;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word counter: cleared on start, advanced after each write; only READ/WRITE expose it, where it is < WORDS.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (state == ST_WRITE) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Request latch: a start consumes it, which also swallows a strobe coincident with the start.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            pending <= 1'b0;
        end else if (start) begin
            pending <= 1'b0;
        end else if (DMA_REQ_WR) begin
            pending <= 1'b1;
        end
    end

    // VBLK history for edge detection, plus the seen-low qualifier.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            vblk_q     <= 1'b0;
            vblk_armed <= 1'b0;
        end else begin
            vblk_q <= VBLK;
            if (!VBLK) begin
                vblk_armed <= 1'b1;
            end
        end
    end

    // Completion pulse in the cycle following the final write.
    always_ff @(posedge DCLK or posedge RESET) begin
        if (RESET) begin
            done_q <= 1'b0;
        end else begin
            done_q <= last_wr;
        end
    end

endmodule
